// File: rtl/sopc_sysid_ext.sv
// sopc_sysid_ext: system identification slave with scratch, uptime counter
// and capability registers on a fixed-latency, never-stalling read bus.
//
// Parameters:
//   ID_VALUE        system ID word (address 0)
//   TIMESTAMP_VALUE build timestamp word (address 1)
//   READ_LATENCY    cycles from read to readdatavalid (1..4)
//   PRESCALE        clocks per uptime tick (1..65535)
//   SCRATCH_RESET   scratch register reset value
//
// Ports:
//   clock          single clock, rising edge
//   reset          asynchronous, active-high reset
//   address[2:0]   word address
//   read           read strobe (wins over a simultaneous write)
//   write          write strobe
//   writedata[31:0] write data
//   readdata[31:0] read data, zero whenever readdatavalid is low
//   readdatavalid  one-cycle read response strobe
module sopc_sysid_ext #(
  parameter logic [31:0] ID_VALUE        = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'h0000_0000,
  parameter int unsigned READ_LATENCY    = 1,
  parameter int unsigned PRESCALE        = 1,
  parameter logic [31:0] SCRATCH_RESET   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  typedef enum logic [2:0] {
    REG_ID        = 3'd0,
    REG_TIMESTAMP = 3'd1,
    REG_SCRATCH   = 3'd2,
    REG_UPTIME_LO = 3'd3,
    REG_UPTIME_HI = 3'd4,
    REG_CONTROL   = 3'd5,
    REG_CAPS      = 3'd6,
    REG_RESERVED  = 3'd7
  } reg_addr_e;

  if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
    $error("READ_LATENCY must be in 1..4");
  end
  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("PRESCALE must be in 1..65535");
  end

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);
  localparam logic [7:0]  CAPS_LAT  = 8'(READ_LATENCY);

  reg_addr_e   w_addr;
  logic        w_wr_acc;
  logic        w_clear;
  logic [31:0] w_rdata;

  logic [63:0] r_uptime;
  logic [15:0] r_presc;
  logic [31:0] r_shadow_hi;
  logic [31:0] r_scratch;
  logic        r_enable;

  logic [31:0]             r_pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] r_pipe_vld;

  assign w_addr   = reg_addr_e'(address);
  // A read in the same cycle suppresses the write entirely.
  assign w_wr_acc = write & ~read;
  assign w_clear  = w_wr_acc && (w_addr == REG_CONTROL) && writedata[1];

  // Uptime counter: clear has priority over the enabled tick.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_uptime <= '0;
      r_presc  <= '0;
    end else if (w_clear) begin
      r_uptime <= '0;
      r_presc  <= '0;
    end else if (r_enable) begin
      if (r_presc == PRESC_MAX) begin
        r_presc  <= '0;
        r_uptime <= r_uptime + 64'd1;
      end else begin
        r_presc <= r_presc + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_scratch <= SCRATCH_RESET;
      r_enable  <= 1'b1;
    end else if (w_wr_acc) begin
      case (w_addr)
        REG_SCRATCH: r_scratch <= writedata;
        REG_CONTROL: r_enable  <= writedata[0];
        default: ;
      endcase
    end
  end

  // HI shadow is latched on the same edge that samples LO for the response.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shadow_hi <= '0;
    end else if (read && (w_addr == REG_UPTIME_LO)) begin
      r_shadow_hi <= r_uptime[63:32];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      REG_ID:        w_rdata = ID_VALUE;
      REG_TIMESTAMP: w_rdata = TIMESTAMP_VALUE;
      REG_SCRATCH:   w_rdata = r_scratch;
      REG_UPTIME_LO: w_rdata = r_uptime[31:0];
      REG_UPTIME_HI: w_rdata = r_shadow_hi;
      REG_CONTROL:   w_rdata = {31'h0, r_enable};
      REG_CAPS:      w_rdata = {16'h0, PRESC_MAX[7:0], CAPS_LAT};
      default:       w_rdata = '0;
    endcase
  end

  // Response pipeline; data is zeroed in invalid slots so the output is
  // zero whenever readdatavalid is low without an output mux.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pipe_vld <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) begin
        r_pipe_data[i] <= '0;
      end
    end else begin
      r_pipe_vld[0]  <= read;
      r_pipe_data[0] <= read ? w_rdata : '0;
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_data[i] <= r_pipe_data[i-1];
      end
    end
  end

  assign readdata      = r_pipe_data[READ_LATENCY-1];
  assign readdatavalid = r_pipe_vld[READ_LATENCY-1];

endmodule

// File: tb/tb_sopc_sysid_ext.sv
// Scoreboard bench for sopc_sysid_ext: two instances, one with
// READ_LATENCY=3/PRESCALE=4 and one with READ_LATENCY=1/PRESCALE=1.
module tb_sopc_sysid_ext;

  localparam logic [31:0] ID_A   = 32'h65AA_F16E;
  localparam logic [31:0] TS_A   = 32'h5F00_1234;
  localparam logic [31:0] SCR_A  = 32'hA5A5_0001;
  localparam logic [31:0] CAPS_A = 32'h0000_0303;
  localparam logic [31:0] CAPS_B = 32'h0000_0001;

  typedef struct {
    string       tag;
    int          kind;   // 0 exact, 1 range [lo,hi], 2 equal to previous response
    logic [31:0] lo;
    logic [31:0] hi;
  } sb_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  a_address = '0, b_address = '0;
  logic        a_read = 1'b0, a_write = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [31:0] a_writedata = '0, b_writedata = '0;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rdv, b_rdv;

  sb_t         q_a[$];
  sb_t         q_b[$];
  logic [31:0] a_last = '0, b_last = '0;
  int          n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  sopc_sysid_ext #(
    .ID_VALUE(ID_A), .TIMESTAMP_VALUE(TS_A), .READ_LATENCY(3),
    .PRESCALE(4), .SCRATCH_RESET(SCR_A)
  ) u_dut (
    .clock(clock), .reset(reset), .address(a_address), .read(a_read),
    .write(a_write), .writedata(a_writedata), .readdata(a_rdata),
    .readdatavalid(a_rdv)
  );

  sopc_sysid_ext #(
    .ID_VALUE(32'h0000_0B0B), .TIMESTAMP_VALUE(32'h0), .READ_LATENCY(1),
    .PRESCALE(1), .SCRATCH_RESET(32'h0)
  ) u_dut1 (
    .clock(clock), .reset(reset), .address(b_address), .read(b_read),
    .write(b_write), .writedata(b_writedata), .readdata(b_rdata),
    .readdatavalid(b_rdv)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic sb_t ex(input string tag, input logic [31:0] v);
    sb_t e;
    e.tag = tag; e.kind = 0; e.lo = v; e.hi = v;
    return e;
  endfunction

  function automatic sb_t rng(input string tag, input logic [31:0] lo, input logic [31:0] hi);
    sb_t e;
    e.tag = tag; e.kind = 1; e.lo = lo; e.hi = hi;
    return e;
  endfunction

  function automatic sb_t same(input string tag);
    sb_t e;
    e.tag = tag; e.kind = 2; e.lo = '0; e.hi = '0;
    return e;
  endfunction

  task automatic sb_eval(input sb_t e, input logic [31:0] got, input logic [31:0] prev);
    case (e.kind)
      0: chk(e.tag, got, e.lo);
      1: chk($sformatf("%s value=%0d range=%0d..%0d", e.tag, got, e.lo, e.hi),
             32'(got >= e.lo && got <= e.hi), 32'd1);
      default: chk(e.tag, got, prev);
    endcase
  endtask

  // Response monitors sample on the falling edge.
  always @(negedge clock) begin
    sb_t ea;
    if (a_rdv) begin
      if (q_a.size() == 0) chk("A_spurious_rdv", 32'(a_rdv), 32'd0);
      else begin
        ea = q_a.pop_front();
        sb_eval(ea, a_rdata, a_last);
        a_last = a_rdata;
      end
    end else chk("A_idle_data_zero", a_rdata, 32'd0);
  end

  always @(negedge clock) begin
    sb_t eb;
    if (b_rdv) begin
      if (q_b.size() == 0) chk("B_spurious_rdv", 32'(b_rdv), 32'd0);
      else begin
        eb = q_b.pop_front();
        sb_eval(eb, b_rdata, b_last);
        b_last = b_rdata;
      end
    end else chk("B_idle_data_zero", b_rdata, 32'd0);
  end

  task automatic a_rd(input logic [2:0] adr, input sb_t e);
    a_read = 1'b1; a_address = adr; q_a.push_back(e);
    @(posedge clock); #1;
    a_read = 1'b0;
  endtask

  task automatic a_wr(input logic [2:0] adr, input logic [31:0] d);
    a_write = 1'b1; a_address = adr; a_writedata = d;
    @(posedge clock); #1;
    a_write = 1'b0;
  endtask

  task automatic b_rd(input logic [2:0] adr, input sb_t e);
    b_read = 1'b1; b_address = adr; q_b.push_back(e);
    @(posedge clock); #1;
    b_read = 1'b0;
  endtask

  task automatic b_wr(input logic [2:0] adr, input logic [31:0] d);
    b_write = 1'b1; b_address = adr; b_writedata = d;
    @(posedge clock); #1;
    b_write = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    chk("timeout", 32'd1, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    idle(2);
    chk("rst_A_rdv", 32'(a_rdv), 32'd0);
    chk("rst_A_rdata", a_rdata, 32'd0);
    chk("rst_B_rdv", 32'(b_rdv), 32'd0);
    reset = 1'b0;

    // Uptime with PRESCALE=4: 40 clocks -> about 10 ticks
    idle(40);
    a_rd(3'd3, rng("A_uptime_40clk", 32'd9, 32'd11));
    b_rd(3'd4, ex("B_hi_reset", 32'd0));
    b_rd(3'd6, ex("B_caps", CAPS_B));
    a_wr(3'd5, 32'd0);
    a_rd(3'd3, rng("A_uptime_disabled", 32'd9, 32'd13));
    idle(20);
    a_rd(3'd3, same("A_uptime_hold"));
    a_rd(3'd5, ex("A_ctrl_off", 32'd0));
    a_wr(3'd5, 32'd3);
    a_rd(3'd3, rng("A_uptime_cleared", 32'd0, 32'd2));
    a_rd(3'd5, ex("A_ctrl_bit1_reads0", 32'd1));

    // Reset-value and constant registers
    a_rd(3'd2, ex("A_scratch_reset", SCR_A));
    a_rd(3'd4, ex("A_hi_shadow", 32'd0));
    a_rd(3'd1, ex("A_timestamp", TS_A));
    a_rd(3'd6, ex("A_caps", CAPS_A));
    a_rd(3'd7, ex("A_reserved", 32'd0));
    idle(6);

    // Exact latency of a single read
    a_rd(3'd0, ex("A_id", ID_A));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clock);
      chk($sformatf("A_lat_cycle%0d", k), 32'(a_rdv), 32'(k == 3));
    end
    @(posedge clock); #1;

    // Scratch write/readback and ignored writes to RO/reserved
    a_wr(3'd2, 32'hDEAD_BEEF);
    a_rd(3'd2, ex("A_scratch_rw", 32'hDEAD_BEEF));
    a_wr(3'd0, 32'h1111_1111);
    a_wr(3'd6, 32'h2222_2222);
    a_wr(3'd7, 32'h3333_3333);
    a_rd(3'd0, ex("A_id_after_wr", ID_A));
    a_rd(3'd6, ex("A_caps_after_wr", CAPS_A));
    a_rd(3'd7, ex("A_reserved_after_wr", 32'd0));

    // Read and write together: read wins
    a_read = 1'b1; a_write = 1'b1; a_address = 3'd2; a_writedata = 32'h0BAD_F00D;
    q_a.push_back(ex("A_rdwr_old", 32'hDEAD_BEEF));
    @(posedge clock); #1;
    a_read = 1'b0; a_write = 1'b0;
    a_rd(3'd2, ex("A_rdwr_unchanged", 32'hDEAD_BEEF));
    idle(6);

    // Back-to-back reads -> consecutive pulses
    a_rd(3'd0, ex("A_b2b_id", ID_A));
    a_rd(3'd1, ex("A_b2b_ts", TS_A));
    a_rd(3'd6, ex("A_b2b_caps", CAPS_A));
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      chk($sformatf("A_b2b_pulse%0d", k), 32'(a_rdv), 32'(k < 3));
    end
    @(posedge clock); #1;

    // 32-bit carry into HI with forced counter (PRESCALE=1)
    b_wr(3'd5, 32'd0);
    force u_dut1.r_uptime = 64'h0000_0000_FFFF_FFFF;
    b_rd(3'd3, ex("B_lo_pre_carry", 32'hFFFF_FFFF));
    b_rd(3'd4, ex("B_hi_pre_carry", 32'd0));
    release u_dut1.r_uptime;
    b_wr(3'd5, 32'd1);
    b_wr(3'd5, 32'd0);
    b_rd(3'd3, ex("B_lo_post_carry", 32'd0));
    b_rd(3'd4, ex("B_hi_post_carry", 32'd1));

    // 64-bit wrap
    force u_dut1.r_uptime = 64'hFFFF_FFFF_FFFF_FFFF;
    b_rd(3'd3, ex("B_lo_pre_wrap", 32'hFFFF_FFFF));
    b_rd(3'd4, ex("B_hi_pre_wrap", 32'hFFFF_FFFF));
    release u_dut1.r_uptime;
    b_wr(3'd5, 32'd1);
    b_wr(3'd5, 32'd0);
    b_rd(3'd3, ex("B_lo_wrap", 32'd0));
    b_rd(3'd4, ex("B_hi_wrap", 32'd0));

    // Clear beats a coincident tick
    b_wr(3'd5, 32'd1);
    idle(5);
    b_wr(3'd5, 32'd3);
    b_rd(3'd3, ex("B_clear_wins", 32'd0));
    idle(6);

    // Reset with reads in flight
    a_rd(3'd0, ex("A_inflight0", ID_A));
    a_rd(3'd1, ex("A_inflight1", TS_A));
    #2;
    reset = 1'b1;
    q_a.delete();
    q_b.delete();
    #1;
    chk("A_rst_async_rdv", 32'(a_rdv), 32'd0);
    chk("A_rst_async_rdata", a_rdata, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    idle(10);
    chk("A_no_rdv_after_rst", 32'(a_rdv), 32'd0);

    a_rd(3'd2, ex("A_scratch_after_rst", SCR_A));
    a_rd(3'd5, ex("A_ctrl_after_rst", 32'd1));
    b_rd(3'd4, ex("B_hi_after_rst", 32'd0));
    idle(8);
    chk("A_sb_drained", q_a.size(), 32'd0);
    chk("B_sb_drained", q_b.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
